// File: rtl/alu_req_arbiter_if.sv
// Shared ALU types plus the bundled request / ALU / response bus of alu_req_arbiter.
// The slave modport is the arbiter side; the master modport is the client/ALU side.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLT = 4'd5
   } opcode_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic negative;
      logic zero;
   } flags_t;

endpackage

interface alu_req_arbiter_if
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_operand_a;
   logic [NUM_REQ*WIDTH-1:0] req_operand_b;
   opcode_e [NUM_REQ-1:0]    req_opcode;
   logic [NUM_REQ-1:0]       req_signed_op;

   logic [WIDTH-1:0]         alu_operand_a;
   logic [WIDTH-1:0]         alu_operand_b;
   opcode_e                  alu_opcode;
   logic                     alu_signed_op;
   logic [WIDTH-1:0]         alu_result;
   flags_t                   alu_flags;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_result;
   flags_t                   rsp_flags;

   modport slave (
      input  req_valid, req_operand_a, req_operand_b, req_opcode, req_signed_op,
      input  alu_result, alu_flags, rsp_ready,
      output req_ready, alu_operand_a, alu_operand_b, alu_opcode, alu_signed_op,
      output rsp_valid, rsp_id, rsp_result, rsp_flags
   );

   modport master (
      output req_valid, req_operand_a, req_operand_b, req_opcode, req_signed_op,
      output alu_result, alu_flags, rsp_ready,
      input  req_ready, alu_operand_a, alu_operand_b, alu_opcode, alu_signed_op,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags
   );

endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Each operation runs grant -> EXEC (one ALU cycle) -> RESP (held until accepted).
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   alu_req_arbiter_if.slave bus,
   output logic             busy,
   output logic [31:0]      ops_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

   state_e           state;
   logic [ID_W-1:0]  ptr;

   logic [WIDTH-1:0] opa_p0;
   logic [WIDTH-1:0] opb_p0;
   opcode_e          op_p0;
   logic             sgn_p0;
   logic [ID_W-1:0]  id_p0;

   logic             vld_p1;
   logic [ID_W-1:0]  id_p1;
   logic [WIDTH-1:0] res_p1;
   flags_t           flags_p1;

   logic             any_valid;
   logic [ID_W-1:0]  win;
   logic [ID_W-1:0]  ptr_nxt;
   logic             rsp_hs;
   logic             grant;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   // Scan from the far end back to ptr so the candidate closest to ptr wins.
   always_comb begin
      win       = ptr;
      any_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         logic [ID_W-1:0] cand;
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            win       = cand;
            any_valid = 1'b1;
         end
      end
   end

   assign ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
   assign rsp_hs  = vld_p1 && bus.rsp_ready;
   assign grant   = !rst && any_valid && ((state == ST_IDLE) || rsp_hs);

   assign bus.req_ready = grant ? (NUM_REQ'(1) << win) : '0;

   assign sel_a = bus.req_operand_a[int'(win)*WIDTH +: WIDTH];
   assign sel_b = bus.req_operand_b[int'(win)*WIDTH +: WIDTH];

   assign bus.alu_operand_a = opa_p0;
   assign bus.alu_operand_b = opb_p0;
   assign bus.alu_opcode    = op_p0;
   assign bus.alu_signed_op = sgn_p0;

   assign bus.rsp_valid  = vld_p1;
   assign bus.rsp_id     = id_p1;
   assign bus.rsp_result = res_p1;
   assign bus.rsp_flags  = flags_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         busy     <= 1'b0;
         ops_done <= '0;
         opa_p0   <= '0;
         opb_p0   <= '0;
         op_p0    <= OP_ADD;
         sgn_p0   <= 1'b0;
         id_p0    <= '0;
         vld_p1   <= 1'b0;
         id_p1    <= '0;
         res_p1   <= '0;
         flags_p1 <= '0;
      end else begin
         // Issue stage: grant latches the winner's operation for EXEC
         if (grant) begin
            opa_p0 <= sel_a;
            opb_p0 <= sel_b;
            op_p0  <= bus.req_opcode[win];
            sgn_p0 <= bus.req_signed_op[win];
            id_p0  <= win;
            ptr    <= ptr_nxt;
         end
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state <= ST_EXEC;
                  busy  <= 1'b1;
               end
            end
            // Response stage: ALU output captured at the end of EXEC
            ST_EXEC: begin
               id_p1    <= id_p0;
               res_p1   <= bus.alu_result;
               flags_p1 <= bus.alu_flags;
               vld_p1   <= 1'b1;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_hs) begin
                  ops_done <= ops_done + 32'd1;
                  vld_p1   <= 1'b0;
                  if (grant) begin
                     state <= ST_EXEC;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy   <= 1'b0;
               vld_p1 <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model (round-robin pick, outstanding-response queue).
module tb_alu_req_arbiter;
   import alu_pkg::*;

   localparam int WIDTH   = 32;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [31:0] ops_done;

   alu_req_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   alu_req_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .ops_done (ops_done)
   );

   always #5 clk = ~clk;

   // Behaviour of the shared ALU: returns {flags, result}
   function automatic logic [35:0] alu_fn(opcode_e op, logic [31:0] a, logic [31:0] b, logic s);
      logic [32:0] w;
      logic [31:0] r;
      flags_t      f;
      w = '0;
      r = '0;
      f = '0;
      case (op)
         OP_ADD: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            f.carry    = w[32];
            f.overflow = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_SUB: begin
            w = {1'b0, a} - {1'b0, b};
            r = w[31:0];
            f.carry    = w[32];
            f.overflow = (a[31] != b[31]) && (r[31] != a[31]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLT: r = s ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
         default: r = '0;
      endcase
      f.zero     = (r == 32'd0);
      f.negative = r[31];
      return {f, r};
   endfunction

   always_comb {bus.alu_flags, bus.alu_result} =
      alu_fn(bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b, bus.alu_signed_op);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          id;
      logic [31:0] res;
      flags_t      fl;
      int          due;
   } rsp_t;

   rsp_t               exp_q[$];
   int                 m_ptr  = 0;
   int                 m_done = 0;
   int                 cyc    = 0;
   logic [31:0]        m_a    = '0;
   logic [31:0]        m_b    = '0;
   opcode_e            m_op   = OP_ADD;
   logic               m_s    = 1'b0;
   logic [NUM_REQ-1:0] acc    = '0;
   int                 grant_log[$];
   int                 grant_cyc[$];

   function automatic int rr_pick(logic [NUM_REQ-1:0] v, int p);
      for (int k = 0; k < NUM_REQ; k++)
         if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic sample();
      logic               exp_vld;
      logic               hs;
      int                 w;
      logic [NUM_REQ-1:0] exp_rdy;
      logic [35:0]        ar;
      rsp_t               e;
      @(negedge clk);
      exp_vld = 1'b0;
      if (exp_q.size() > 0) exp_vld = (cyc >= exp_q[0].due);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_vld));
      if (exp_vld) begin
         check("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
         check("rsp_result", 64'(bus.rsp_result), 64'(exp_q[0].res));
         check("rsp_flags", 64'(bus.rsp_flags), 64'(exp_q[0].fl));
      end
      check("busy", 64'(busy), 64'(exp_q.size() > 0));
      check("ops_done", 64'(ops_done), 64'(m_done));
      check("alu_a", 64'(bus.alu_operand_a), 64'(m_a));
      check("alu_b", 64'(bus.alu_operand_b), 64'(m_b));
      check("alu_op", 64'(bus.alu_opcode), 64'(m_op));
      check("alu_s", 64'(bus.alu_signed_op), 64'(m_s));
      hs      = exp_vld && bus.rsp_ready;
      w       = rr_pick(bus.req_valid, m_ptr);
      exp_rdy = '0;
      if (!rst && (exp_q.size() == 0 || hs) && w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      acc = bus.req_ready & bus.req_valid;
      if (rst) begin
         exp_q.delete();
         m_ptr  = 0;
         m_done = 0;
         m_a    = '0;
         m_b    = '0;
         m_op   = OP_ADD;
         m_s    = 1'b0;
      end else begin
         if (hs) begin
            void'(exp_q.pop_front());
            m_done++;
         end
         if (exp_rdy != '0) begin
            m_a  = bus.req_operand_a[w*WIDTH +: WIDTH];
            m_b  = bus.req_operand_b[w*WIDTH +: WIDTH];
            m_op = bus.req_opcode[w];
            m_s  = bus.req_signed_op[w];
            ar   = alu_fn(m_op, m_a, m_b, m_s);
            e.id  = w;
            e.res = ar[31:0];
            e.fl  = flags_t'(ar[35:32]);
            e.due = cyc + 2;
            exp_q.push_back(e);
            m_ptr = (w + 1) % NUM_REQ;
            grant_log.push_back(w);
            grant_cyc.push_back(cyc);
         end
      end
      cyc++;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input opcode_e op,
                          input logic [31:0] a, input logic [31:0] b, input logic s);
      bus.req_valid[i]                 = v;
      bus.req_opcode[i]                = op;
      bus.req_operand_a[i*WIDTH +: WIDTH] = a;
      bus.req_operand_b[i*WIDTH +: WIDTH] = b;
      bus.req_signed_op[i]             = s;
   endtask

   task automatic rand_req(input int i);
      set_req(i, 1'b1, opcode_e'($urandom_range(0, 5)), $urandom, $urandom, 1'($urandom_range(0, 1)));
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_REQ; i++) bus.req_valid[i] = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         sample();
         advance();
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      run(n);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, OP_ADD, 32'(i), 32'(i), 1'b0);

      // Reset with every requester valid
      repeat (3) begin
         sample();
         check("rst_ops_done", 64'(ops_done), 64'd0);
         check("rst_rsp_res", 64'(bus.rsp_result), 64'd0);
         check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
         check("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
         check("rst_alu_op", 64'(bus.alu_opcode), 64'(OP_ADD));
         check("rst_ready", 64'(bus.req_ready), 64'd0);
         advance();
      end
      rst = 1'b0;
      sample();
      check("rst_first_grant", 64'(bus.req_ready), 64'b0001);
      advance();
      clear_all();

      // Single op: requester 2 ADD 5+7
      do_reset(1);
      bus.rsp_ready = 1'b1;
      set_req(2, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0);
      sample();
      check("single_ready", 64'(bus.req_ready), 64'b0100);
      advance();
      bus.req_valid[2] = 1'b0;
      sample();
      check("single_alu_op", 64'(bus.alu_opcode), 64'(OP_ADD));
      check("single_no_rsp", 64'(bus.rsp_valid), 64'd0);
      advance();
      sample();
      check("single_rsp_vld", 64'(bus.rsp_valid), 64'd1);
      check("single_rsp_id", 64'(bus.rsp_id), 64'd2);
      check("single_rsp_res", 64'(bus.rsp_result), 64'd12);
      check("single_zero", 64'(bus.rsp_flags.zero), 64'd0);
      advance();
      sample();
      check("single_ops_done", 64'(ops_done), 64'd1);
      advance();

      // Fairness: all four requesters always valid with XOR ops
      do_reset(1);
      grant_log.delete();
      grant_cyc.delete();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, OP_XOR, $urandom, 32'(i + 1), 1'b0);
      repeat (12) begin
         sample();
         advance();
         for (int i = 0; i < NUM_REQ; i++)
            if (acc[i]) set_req(i, 1'b1, OP_XOR, $urandom, 32'(i + 1), 1'b0);
      end
      check("fair_ngrants", 64'(grant_log.size() >= 6), 64'd1);
      for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
         check("fair_order", 64'(grant_log[k]), 64'(k % NUM_REQ));
         if (k > 0) check("fair_gap", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd2);
      end
      clear_all();
      run(4);

      // Backpressure: SUB 3-3 held while rsp_ready low
      do_reset(1);
      bus.rsp_ready = 1'b1;
      set_req(1, 1'b1, OP_SUB, 32'd3, 32'd3, 1'b0);
      sample();
      check("bp_ready", 64'(bus.req_ready), 64'b0010);
      advance();
      bus.req_valid[1] = 1'b0;
      set_req(0, 1'b1, OP_XOR, 32'h11, 32'h22, 1'b0);
      set_req(2, 1'b1, OP_XOR, 32'h33, 32'h44, 1'b0);
      set_req(3, 1'b1, OP_XOR, 32'h55, 32'h66, 1'b0);
      bus.rsp_ready = 1'b0;
      run(1);
      repeat (5) begin
         sample();
         check("bp_vld", 64'(bus.rsp_valid), 64'd1);
         check("bp_res", 64'(bus.rsp_result), 64'd0);
         check("bp_zero", 64'(bus.rsp_flags.zero), 64'd1);
         check("bp_no_ready", 64'(bus.req_ready), 64'd0);
         advance();
      end
      bus.rsp_ready = 1'b1;
      sample();
      check("bp_grant_hs", 64'(bus.req_ready), 64'b0100);
      advance();
      clear_all();
      run(4);

      // Pointer skip: ptr is now 3, only 1 and 2 valid
      set_req(1, 1'b1, OP_OR, 32'h1, 32'h2, 1'b0);
      set_req(2, 1'b1, OP_AND, 32'hF, 32'h3, 1'b0);
      sample();
      check("skip_first", 64'(bus.req_ready), 64'b0010);
      advance();
      bus.req_valid[1] = 1'b0;
      run(1);
      sample();
      check("skip_second", 64'(bus.req_ready), 64'b0100);
      advance();
      clear_all();
      run(4);

      // Reset during EXEC
      set_req(0, 1'b1, OP_ADD, 32'd9, 32'd9, 1'b0);
      sample();
      check("mid_grant", 64'(bus.req_ready), 64'b0001);
      advance();
      bus.req_valid[0] = 1'b0;
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      repeat (3) begin
         sample();
         check("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
         check("mid_ops_done", 64'(ops_done), 64'd0);
         advance();
      end
      set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
      set_req(3, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b0);
      sample();
      check("mid_ptr0", 64'(bus.req_ready), 64'b0001);
      advance();
      clear_all();
      run(4);

      // Random traffic with random backpressure
      do_reset(1);
      repeat (3000) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid[i] || acc[i]) begin
               if ($urandom_range(0, 9) < 6) rand_req(i);
               else bus.req_valid[i] = 1'b0;
            end
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         sample();
         advance();
      end
      clear_all();
      bus.rsp_ready = 1'b1;
      run(6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
